gearbox_rx: RTL and testbench

GEARBOX_RX -- requirements
Module: gearbox_rx

---
 rtl/gearbox_rx_if.sv | 34 +++
 rtl/gearbox_rx.sv | 70 +++++++
 tb/tb_gearbox_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gearbox_rx_if.sv
// gearbox_rx_if: serdes word in, sync-header block out.
// Optional GEARBOX_RX_SLIP_CNT_EN carries the slip counter output.
interface gearbox_rx_if #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int IN_W   = 32
);
  logic [IN_W-1:0]   data_i;
  logic              slip_v_i;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;
`ifdef GEARBOX_RX_SLIP_CNT_EN
  logic [7:0]        slip_cnt_o;

  modport master (
    output data_i, slip_v_i,
    input  valid_o, head_o, data_o, slip_cnt_o
  );
  modport slave (
    input  data_i, slip_v_i,
    output valid_o, head_o, data_o, slip_cnt_o
  );
`else
  modport master (
    output data_i, slip_v_i,
    input  valid_o, head_o, data_o
  );
  modport slave (
    input  data_i, slip_v_i,
    output valid_o, head_o, data_o
  );
`endif
endinterface

// File: rtl/gearbox_rx.sv
// gearbox_rx: IN_W-bit serdes words to HEAD_W+DATA_W blocks with bit slip.
// Define GEARBOX_RX_SLIP_CNT_EN to add the saturating slip_cnt_o counter.
module gearbox_rx #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int IN_W   = 32
) (
  input logic       clk,
  input logic       nreset,
  gearbox_rx_if.slave bus
);
  localparam int BLK_W = HEAD_W + DATA_W;
  localparam int BUF_W = BLK_W + IN_W - 1;
  localparam int CNT_W = $clog2(BLK_W + IN_W);
  localparam logic [CNT_W-1:0] BLK_C = CNT_W'(BLK_W);
  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [BUF_W-1:0] sr_q;
  logic [BUF_W-1:0] sr_d;
  logic [BUF_W-1:0] cat;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic [CNT_W-1:0] total;
  logic             blk_ok;

  // Bits above fill_q are always zero, so OR-ing in the new word is enough.
  always_comb begin
    cat   = sr_q | (BUF_W'(bus.data_i) << fill_q);
    total = fill_q + IN_C;
    if (bus.slip_v_i) begin
      cat   = cat >> 1;
      total = total - ONE_C;
    end
    blk_ok = (total >= BLK_C);
    sr_d   = cat;
    fill_d = total;
    if (blk_ok) begin
      sr_d   = cat >> BLK_W;
      fill_d = total - BLK_C;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sr_q        <= '0;
      fill_q      <= '0;
      bus.valid_o <= 1'b0;
      bus.head_o  <= '0;
      bus.data_o  <= '0;
    end else begin
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      bus.valid_o <= blk_ok;
      if (blk_ok) begin
        {bus.data_o, bus.head_o} <= cat[BLK_W-1:0];
      end
    end
  end

`ifdef GEARBOX_RX_SLIP_CNT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.slip_cnt_o <= '0;
    end else if (bus.slip_v_i && (bus.slip_cnt_o != 8'hff)) begin
      bus.slip_cnt_o <= bus.slip_cnt_o + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gearbox_rx.sv
// tb_gearbox_rx: directed steps against a bit-queue scoreboard.
// Slip counter checks run only with GEARBOX_RX_SLIP_CNT_EN defined.
module tb_gearbox_rx;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int checks = 0;
  int errors = 0;
  int nvalid = 0;

  bit mq[$];
  logic [65:0] exq[$];
  bit ev;
  bit hchk;
  bit tx[$];

  gearbox_rx_if #(.HEAD_W(2), .DATA_W(64), .IN_W(32)) bus ();

  gearbox_rx #(.HEAD_W(2), .DATA_W(64), .IN_W(32)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] d, input logic s);
    logic [65:0] blk;
    for (int i = 0; i < 32; i++) mq.push_back(d[i]);
    if (s) void'(mq.pop_front());
    ev = 1'b0;
    if (mq.size() >= 66) begin
      for (int i = 0; i < 66; i++) blk[i] = mq.pop_front();
      exq.push_back(blk);
      ev = 1'b1;
    end
  endtask

  task automatic step(input logic [31:0] d, input logic s);
    logic [65:0] exp;
    logic legal;
    bus.data_i   = d;
    bus.slip_v_i = s;
    model(d, s);
    @(posedge clk);
    #1;
    chk("valid", 128'(bus.valid_o), 128'(ev));
    if (bus.valid_o) nvalid++;
    if (ev) begin
      exp = exq.pop_front();
      chk("block", 128'({bus.data_o, bus.head_o}), 128'(exp));
      if (hchk) begin
        legal = (bus.head_o == 2'b01) || (bus.head_o == 2'b10);
        chk("head_legal", 128'(legal), 128'(1'b1));
      end
    end
    bus.slip_v_i = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    bus.data_i = '0;
    bus.slip_v_i = 1'b0;
    mq.delete();
    exq.delete();
    hchk = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    nreset = 1'b1;
  endtask

  task automatic pat_w012();
    step(32'h00000001, 1'b0);
    step(32'hAAAAAAAA, 1'b0);
    chk("w01_valid", 128'(bus.valid_o), 128'(1'b0));
    step(32'h00000002, 1'b0);
    chk("w2_valid", 128'(bus.valid_o), 128'(1'b1));
    chk("w2_head", 128'(bus.head_o), 128'(2'b01));
    chk("w2_data", 128'(bus.data_o),
        128'({2'b10, 32'hAAAAAAAA, 30'h0}));
  endtask

  task automatic aligned_run(input int k);
    logic [31:0] w;
    do_reset();
    tx.delete();
    for (int i = 0; i < k; i++) tx.push_back(1'($urandom()));
    for (int b = 0; b < 70; b++) begin
      if ($urandom_range(1)) begin
        tx.push_back(1'b1); tx.push_back(1'b0);
      end else begin
        tx.push_back(1'b0); tx.push_back(1'b1);
      end
      for (int i = 0; i < 64; i++) tx.push_back(1'($urandom()));
    end
    for (int c = 0; c < k + 60; c++) begin
      for (int i = 0; i < 32; i++) w[i] = tx.pop_front();
      hchk = (c >= k + 1);
      step(w, c < k);
    end
    hchk = 1'b0;
  endtask

  initial begin
    bus.data_i = '0;
    bus.slip_v_i = 1'b0;
    hchk = 1'b0;
    ev = 1'b0;

    do_reset();
    chk("rst_valid", 128'(bus.valid_o), 128'(1'b0));
    chk("rst_head", 128'(bus.head_o), 128'(2'b00));
    chk("rst_data", 128'(bus.data_o), 128'(64'h0));
    chk("rst_fill", 128'(dut.fill_q), 128'(0));

    pat_w012();

    do_reset();
    nvalid = 0;
    for (int c = 0; c < 66; c++) step($urandom(), 1'b0);
    chk("count66", 128'(nvalid), 128'(66 * 32 / 66));

    aligned_run(0);
    aligned_run(1);
    aligned_run(33);
    aligned_run(65);

    do_reset();
    for (int c = 0; c < 32; c++) step($urandom(), 1'b0);
    chk("fill34", 128'(dut.fill_q), 128'(34));
    step($urandom(), 1'b1);
    chk("slip66_valid", 128'(bus.valid_o), 128'(1'b0));
    chk("fill65", 128'(dut.fill_q), 128'(65));
    step($urandom(), 1'b0);
    step($urandom(), 1'b1);
    step($urandom(), 1'b1);
    for (int c = 0; c < 6; c++) step($urandom(), 1'b0);

    do_reset();
    for (int c = 0; c < 26; c++) step($urandom(), 1'b0);
    chk("fill40", 128'(dut.fill_q), 128'(40));
    nreset = 1'b0;
    #1;
    chk("mid_valid", 128'(bus.valid_o), 128'(1'b0));
    chk("mid_head", 128'(bus.head_o), 128'(2'b00));
    chk("mid_data", 128'(bus.data_o), 128'(64'h0));
    mq.delete();
    exq.delete();
    #10;
    nreset = 1'b1;
    pat_w012();

`ifdef GEARBOX_RX_SLIP_CNT_EN
    do_reset();
    chk("cnt_rst", 128'(bus.slip_cnt_o), 128'(0));
    for (int c = 0; c < 3; c++) step($urandom(), 1'b1);
    chk("cnt3", 128'(bus.slip_cnt_o), 128'(3));
    for (int c = 0; c < 297; c++) step($urandom(), 1'b1);
    chk("cnt_sat", 128'(bus.slip_cnt_o), 128'(255));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
